// File: rtl/led_breather.sv
// PWM breathing-fade LED driver: ramps brightness up/down following the BLINK level.
// Optional quadratic perceptual duty curve enabled by defining LED_GAMMA_EN.
module led_breather #(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned RAMP_DIV = 16
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                ENABLE,
    input  logic                BLINK,
    output logic                LED,
    output logic [PWM_BITS-1:0] LEVEL,
    output logic                BUSY
);

    localparam int unsigned STEP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned SQ_W   = 2 * PWM_BITS;

    localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;
    localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);
    localparam logic [STEP_W-1:0]   STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(RAMP_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        HIGH = 2'd2,
        FALL = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                blink_q, blink_d;
    logic                blink_qq, blink_qq_d;
    logic                led_q, led_d;
    logic                busy_q, busy_d;

    logic                rise_c;
    logic                fall_c;
    logic                boundary_c;
    logic [PWM_BITS-1:0] duty_src_c;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= IDLE;
            level_q    <= '0;
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
            duty_q     <= '0;
            blink_q    <= 1'b0;
            blink_qq   <= 1'b0;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
            duty_q     <= duty_d;
            blink_q    <= blink_d;
            blink_qq   <= blink_qq_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        blink_d    = BLINK;
        blink_qq_d = blink_q;
        rise_c     = blink_q & ~blink_qq;
        fall_c     = ~blink_q & blink_qq;
        boundary_c = (pwm_cnt_q == LVL_MAX);
        pwm_cnt_d  = pwm_cnt_q + LVL_ONE;
    end

    // Ramp state machine; edges take priority over a coincident step.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        step_cnt_d = step_cnt_q;
        if (!ENABLE) begin
            state_d    = IDLE;
            level_d    = '0;
            step_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    level_d    = '0;
                    step_cnt_d = '0;
                    if (rise_c) begin
                        state_d = RISE;
                    end
                end
                RISE: begin
                    if (fall_c) begin
                        state_d    = FALL;
                        step_cnt_d = '0;
                    end else if (boundary_c) begin
                        if (step_cnt_q == STEP_LAST) begin
                            step_cnt_d = '0;
                            if (level_q >= LVL_MAX - LVL_ONE) begin
                                level_d = LVL_MAX;
                                state_d = HIGH;
                            end else begin
                                level_d = level_q + LVL_ONE;
                            end
                        end else begin
                            step_cnt_d = step_cnt_q + STEP_ONE;
                        end
                    end
                end
                HIGH: begin
                    level_d    = LVL_MAX;
                    step_cnt_d = '0;
                    if (fall_c) begin
                        state_d = FALL;
                    end
                end
                FALL: begin
                    if (rise_c) begin
                        state_d    = RISE;
                        step_cnt_d = '0;
                    end else if (boundary_c) begin
                        if (step_cnt_q == STEP_LAST) begin
                            step_cnt_d = '0;
                            if (level_q <= LVL_ONE) begin
                                level_d = '0;
                                state_d = IDLE;
                            end else begin
                                level_d = level_q - LVL_ONE;
                            end
                        end else begin
                            step_cnt_d = step_cnt_q + STEP_ONE;
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    level_d    = '0;
                    step_cnt_d = '0;
                end
            endcase
        end
    end

    // Duty follows the upcoming level so a finished fade never leaves a stale pulse.
`ifdef LED_GAMMA_EN
    logic [SQ_W-1:0] level_sq_c;
    always_comb begin
        level_sq_c = SQ_W'(level_d) * SQ_W'(level_d);
        duty_src_c = level_sq_c[SQ_W-1:PWM_BITS];
    end
`else
    always_comb begin
        duty_src_c = level_d;
    end
`endif

    always_comb begin
        duty_d = duty_q;
        led_d  = 1'b0;
        busy_d = (state_d != IDLE);
        if (!ENABLE) begin
            duty_d = '0;
        end else if (boundary_c) begin
            duty_d = duty_src_c;
        end
        if (ENABLE) begin
            if ((state_q == HIGH) || (duty_q == LVL_MAX)) begin
                led_d = 1'b1;
            end else begin
                led_d = (pwm_cnt_q < duty_q);
            end
        end
    end

    assign LED   = led_q;
    assign LEVEL = level_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_led_breather.sv
// Directed bench for led_breather with PWM_BITS=4, RAMP_DIV=2 (16-clock period, 32-clock step).
module tb_led_breather;

    localparam int unsigned NR = 560;
    localparam int unsigned NV = 17;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       blink = 1'b0;
    logic       led;
    logic [3:0] level;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       blink;
        logic       exp_led;
        logic [3:0] exp_level;
        logic       exp_busy;
    } vec_t;

    vec_t       vecs [0:NV-1];
    logic       led_hist  [0:NR];
    logic [3:0] lvl_hist  [0:NR];
    logic       busy_hist [0:NR];
    int         t_lvl     [0:15];

    led_breather #(.PWM_BITS(4), .RAMP_DIV(2)) dut (
        .CLOCK (clk),
        .RESET (rst),
        .ENABLE(en),
        .BLINK (blink),
        .LED   (led),
        .LEVEL (level),
        .BUSY  (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_vecs(input int first, input int last, input string tag);
        for (int i = first; i <= last; i++) begin
            rst   = vecs[i].rst;
            en    = vecs[i].en;
            blink = vecs[i].blink;
            tick();
            check($sformatf("%s[%0d].led", tag, i), int'(led), int'(vecs[i].exp_led));
            check($sformatf("%s[%0d].level", tag, i), int'(level), int'(vecs[i].exp_level));
            check($sformatf("%s[%0d].busy", tag, i), int'(busy), int'(vecs[i].exp_busy));
        end
    endtask

    initial begin
        int exp_hi8;
        int bad;
        int sum;
        int t_idle;
        int found;

`ifdef LED_GAMMA_EN
        exp_hi8 = 4;
`else
        exp_hi8 = 8;
`endif
        //             rst   en    blink led   lvl   busy
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
        // Enable drop from HIGH, then BLINK edges with enable low.
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};

        apply_vecs(0, 6, "reset");

        // Full rise: record every cycle, then analyse.
        led_hist[0]  = led;
        lvl_hist[0]  = level;
        busy_hist[0] = busy;
        blink = 1'b1;
        for (int n = 1; n <= NR; n++) begin
            tick();
            led_hist[n]  = led;
            lvl_hist[n]  = level;
            busy_hist[n] = busy;
        end
        check("rise.busy_after_1", int'(busy_hist[1]), 0);
        check("rise.busy_after_2", int'(busy_hist[2]), 1);

        for (int k = 0; k < 16; k++) t_lvl[k] = 0;
        bad = 0;
        for (int n = 1; n <= NR; n++) begin
            if (lvl_hist[n] != lvl_hist[n-1]) begin
                if (lvl_hist[n] != lvl_hist[n-1] + 4'd1) bad++;
                if (t_lvl[lvl_hist[n]] == 0) t_lvl[lvl_hist[n]] = n;
            end
        end
        check("rise.level_steps_by_one", bad, 0);
        bad = 0;
        for (int k = 2; k < 16; k++) begin
            if (t_lvl[k] - t_lvl[k-1] != 32) bad++;
        end
        check("rise.step_spacing_32", bad, 0);
        check("rise.full_ramp_time_in_464_496",
              int'(t_lvl[15] >= 464 && t_lvl[15] <= 496), 1);

        sum = 0;
        if (t_lvl[1] >= 16) begin
            for (int n = t_lvl[1] - 15; n <= t_lvl[1]; n++) sum += int'(led_hist[n]);
        end else begin
            sum = -1;
        end
        check("pwm.duty0_high_count", sum, 0);

        sum = 0;
        if (t_lvl[8] > 0 && t_lvl[8] + 16 <= NR) begin
            for (int n = t_lvl[8] + 1; n <= t_lvl[8] + 16; n++) sum += int'(led_hist[n]);
        end else begin
            sum = -1;
        end
        check("pwm.level8_high_count", sum, exp_hi8);

        bad = 0;
        if (t_lvl[15] == 0) bad = 1;
        else begin
            for (int n = t_lvl[15] + 1; n <= NR; n++) begin
                if (led_hist[n] !== 1'b1 || busy_hist[n] !== 1'b1) bad++;
            end
        end
        check("high.led_and_busy_constant", bad, 0);
        check("high.level_max", int'(level), 15);

        apply_vecs(7, 16, "enable_drop");

        // Abort rise at level 6.
        blink = 1'b1;
        found = 0;
        for (int n = 0; n < 300 && found == 0; n++) begin
            tick();
            if (level == 4'd6) found = 1;
        end
        check("abort.reached_level6", found, 1);
        blink = 1'b0;
        t_idle = 0;
        bad = 0;
        lvl_hist[0] = level;
        for (int n = 1; n <= 260 && t_idle == 0; n++) begin
            tick();
            if (n == 2) check("abort.busy_in_fall", int'(busy), 1);
            if (level > lvl_hist[0]) bad++;
            lvl_hist[0] = level;
            if (busy == 1'b0) t_idle = n;
        end
        check("abort.level_never_rises", bad, 0);
        check("abort.idle_time_in_176_208", int'(t_idle >= 176 && t_idle <= 208), 1);
        check("abort.level_zero_at_idle", int'(level), 0);
        bad = 0;
        for (int n = 0; n < 17; n++) begin
            tick();
            if (led !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("abort.dark_after_idle", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
